viterbi_traceback_ctrl: RTL and testbench

//  Survivor-memory and traceback controller for the 4-state (K=3) Viterbi decoder. Stores one
//  4-bit ACS decision column per symbol in a 3*TBL-deep ring buffer. Every TBL symbols it

---
 rtl/viterbi_traceback_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_viterbi_traceback_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback_ctrl.sv
// ============================================================================
// viterbi_traceback_ctrl
// ----------------------------------------------------------------------------
// Survivor-memory and traceback controller for a 4-state (K=3) Viterbi
// decoder. Each accepted symbol stores one 4-bit ACS decision column in a
// ring buffer that is 3*TBL columns deep. After every TBL new columns the
// controller traces back 2*TBL columns. It starts from the best state that
// the min-metric selector reported for the newest column. The first TBL steps
// only let the path merge. The second TBL steps produce TBL decoded bits,
// which are handed downstream oldest first.
//
// Parameters
//   TBL  traceback / decode block length in symbols (2..85)
//   PW   ring-buffer pointer width, 3*TBL must fit in 2**PW
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    decision column offered by the ACS unit
//   in_ready    controller can take the column (write = in_valid & in_ready)
//   surv        decision bits, surv[s] belongs to state s
//   best_state  min-metric state for the column being written
//   out_valid   decoded bit available
//   out_ready   downstream takes the bit
//   out_bit     decoded bit, oldest of the block first
//   out_last    marks the newest (TBL-th) bit of each block
// ============================================================================
module viterbi_traceback_ctrl #(
    parameter int TBL = 8,
    parameter int PW  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] surv,
    input  logic [1:0] best_state,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last
);

    localparam int DEPTH = 3 * TBL;
    localparam int IW    = (TBL > 1) ? $clog2(TBL) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(TBL - 1);

    typedef enum logic [1:0] {
        IDLE,
        MERGE,
        DECODE,
        HOLD
    } fsm_t;

    fsm_t fsm;
    fsm_t fsm_next;

    logic [3:0]     mem [DEPTH];
    logic [PW-1:0]  wp;
    logic [PW-1:0]  rp;
    logic [IW-1:0]  cnt_new;
    logic [IW-1:0]  step;
    logic [IW-1:0]  out_idx;
    logic           primed;
    logic [1:0]     tb_state;
    logic [TBL-1:0] tbuf;
    logic [TBL-1:0] obuf;

    logic wr_en;
    logic block_done;
    logic start;
    logic step_last;
    logic tracing;
    logic load_out;
    logic out_fire;
    logic tb_bit;

    // The last column of a block is held off while a traceback or a pending
    // hand-off is still in progress. This keeps a new start from overlapping
    // a busy FSM. It also keeps writes from reaching columns that are still
    // being traced.
    assign in_ready   = !(cnt_new == LAST_IDX && fsm != IDLE);
    assign wr_en      = in_valid && in_ready;
    assign block_done = wr_en && (cnt_new == LAST_IDX);
    // The first completed block after reset only fills the history.
    // A traceback is not possible until 2*TBL columns exist.
    assign start      = block_done && primed;
    assign step_last  = (step == LAST_IDX);
    assign tracing    = (fsm == MERGE) || (fsm == DECODE);
    assign load_out   = (fsm == HOLD) && !out_valid;
    assign out_fire   = out_valid && out_ready;

    // One trellis step reads the survivor bit of the current state. Reads see
    // the pre-write contents. rp never equals wp while tracing.
    assign tb_bit = mem[rp][tb_state];

    // The output is forced low when idle so it stays quiet between blocks.
    assign out_bit  = out_valid && obuf[out_idx];
    assign out_last = out_valid && (out_idx == LAST_IDX);

    // Survivor memory. It has no reset on purpose. The primed/cnt_new
    // bookkeeping guarantees that stale columns are never traced.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= surv;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Next-state logic. MERGE and DECODE each last exactly TBL steps.
    // HOLD waits until the previous block has fully drained from the
    // output buffer.
    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (start)      fsm_next = MERGE;
            MERGE:   if (step_last)  fsm_next = DECODE;
            DECODE:  if (step_last)  fsm_next = HOLD;
            HOLD:    if (!out_valid) fsm_next = IDLE;
            default:                 fsm_next = IDLE;
        endcase
    end

    // Write side and traceback datapath. A start captures the newest column
    // as the read pointer and the selector's best state as the path head.
    // Each traceback step then moves to the predecessor {s[0], surv[s]}
    // one column back. During DECODE, s[1] is the decoded bit of the current
    // column. Bits arrive newest first, so they are stored reversed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            rp       <= '0;
            cnt_new  <= '0;
            primed   <= 1'b0;
            tb_state <= '0;
            step     <= '0;
            tbuf     <= '0;
        end else begin
            if (wr_en) begin
                wp <= (wp == LAST_PTR) ? '0 : wp + PW'(1);
                if (block_done) begin
                    cnt_new <= '0;
                    primed  <= 1'b1;
                end else begin
                    cnt_new <= cnt_new + IW'(1);
                end
            end

            if (start) begin
                tb_state <= best_state;
                rp       <= wp;
                step     <= '0;
            end else if (tracing) begin
                tb_state <= {tb_state[0], tb_bit};
                rp       <= (rp == '0) ? LAST_PTR : rp - PW'(1);
                step     <= step_last ? '0 : step + IW'(1);
                if (fsm == DECODE) begin
                    tbuf[LAST_IDX - step] <= tb_state[1];
                end
            end
        end
    end

    // Output buffer. A finished block is copied only once the previous one
    // has drained. After that the traceback buffer is free for the next
    // block, while these bits trickle out one per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            obuf      <= '0;
        end else if (load_out) begin
            obuf      <= tbuf;
            out_valid <= 1'b1;
            out_idx   <= '0;
        end else if (out_fire) begin
            if (out_idx == LAST_IDX) begin
                out_valid <= 1'b0;
                out_idx   <= '0;
            end else begin
                out_idx <= out_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_viterbi_traceback_ctrl.sv
// ============================================================================
// tb_viterbi_traceback_ctrl
// ----------------------------------------------------------------------------
// Bench for the traceback controller with TBL=4, PW=4. The driver creates
// decision columns from a known message. For each symbol b_t the true state is
// {b_t, b_t-1}. That state's survivor bit is b_t-2, and best_state is the true
// state. The other survivor bits are random.
//
// Tracing from the true state therefore has to reproduce the message exactly.
// The reference model only counts accepted columns. At every TBL-th column
// from the 2*TBL-th onward, it queues the TBL message bits that start 2*TBL
// columns back. The monitor pops and compares on every output handshake.
// ============================================================================
module tb_viterbi_traceback_ctrl;

    localparam int TBL = 4;
    localparam int PW  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] surv = 4'h0;
    logic [1:0] best_state = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_bit;
    logic       out_last;

    int check_count = 0;
    int pass_count  = 0;

    bit exp_q[$];
    bit exp_last_q[$];
    bit hist[$];
    int wr_count = 0;
    bit cur_bit = 1'b0;
    bit drv_b1 = 1'b0;
    bit drv_b2 = 1'b0;
    bit stall_seen = 1'b0;
    bit stall_bit = 1'b0;
    bit stall_last = 1'b0;
    bit saw_ready_low = 1'b0;

    always #5 clk = ~clk;

    viterbi_traceback_ctrl #(
        .TBL(TBL),
        .PW (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .surv      (surv),
        .best_state(best_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    // Common comparison helper. It also keeps the pass and total counts.
    task automatic checkOutput(input string name, input int got, input int exp);
        check_count++;
        if (got == exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model and scoreboard run at the falling edge, where handshake signals
    // are stable. Accepted columns feed the message history. Output
    // handshakes pop the expected bits. Stalled outputs must not change.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_last_q.delete();
            hist.delete();
            wr_count   = 0;
            stall_seen = 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                saw_ready_low = 1'b1;
            end
            if (in_valid && in_ready) begin
                hist.push_back(cur_bit);
                wr_count++;
                if ((wr_count % TBL) == 0 && wr_count >= 2 * TBL) begin
                    for (int i = 0; i < TBL; i++) begin
                        exp_q.push_back(hist[wr_count - 2 * TBL + i]);
                        exp_last_q.push_back(i == TBL - 1);
                    end
                end
            end
            if (stall_seen && out_valid) begin
                checkOutput("stall_bit", out_bit, stall_bit);
                checkOutput("stall_last", out_last, stall_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", out_valid, 0);
                end else begin
                    checkOutput("out_bit", out_bit, exp_q.pop_front());
                    checkOutput("out_last", out_last, exp_last_q.pop_front());
                end
            end
            stall_seen = out_valid && !out_ready;
            stall_bit  = out_bit;
            stall_last = out_last;
        end
    end

    // Offers one column for message bit b. The task waits for the controller
    // to accept it and returns just after the accepting edge with in_valid
    // still high, so back-to-back calls stream continuously.
    task automatic applyStimulus(input bit b, input bit rnd);
        logic [1:0] s;
        logic [3:0] sv;
        int waited;
        s = {b, drv_b1};
        sv = rnd ? 4'($urandom) : 4'h0;
        sv[s] = drv_b2;
        surv       = sv;
        best_state = s;
        cur_bit    = b;
        in_valid   = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", in_ready, 1);
        end
        @(posedge clk);
        #1;
        drv_b2 = drv_b1;
        drv_b1 = b;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        drv_b1   = 1'b0;
        drv_b2   = 1'b0;
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_bit", out_bit, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Lets every expected bit come out, then confirms that nothing else follows.
    task automatic waitDrain();
        int waited;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 400) begin
            @(posedge clk);
            waited++;
        end
        #1;
        checkOutput("drain_pending_bits", exp_q.size(), 0);
        idleCycles(3 * TBL + 4);
    endtask

    task automatic waitOutValid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, out_valid, 1);
    endtask

    initial begin
        int cycles;
        bit known [8];
        known = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Startup: seven all-zero columns give no output. The eighth starts
        // a traceback, and the output must appear 2*TBL+1 edges later.
        $display("[TB] startup");
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * TBL - 1; i++) applyStimulus(1'b0, 1'b0);
        idleCycles(12);
        checkOutput("startup_no_output", out_valid, 0);
        applyStimulus(1'b0, 1'b0);
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("startup_latency", cycles, 2 * TBL + 1);
        waitDrain();

        // Known message: the first block must read 1,0,1,1.
        $display("[TB] known path");
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(known[i], 1'b1);
        waitDrain();

        // Backpressure: continuous input while the output is stalled.
        $display("[TB] backpressure");
        doReset();
        out_ready     = 1'b0;
        saw_ready_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) applyStimulus(1'($urandom), 1'b1);
                in_valid = 1'b0;
            end
            begin
                repeat (60) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        checkOutput("backpressure_in_ready_low", saw_ready_low, 1);
        checkOutput("backpressure_writes", wr_count, 20);
        waitDrain();

        // Long random stream that wraps the pointers several times.
        $display("[TB] wrap");
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) applyStimulus(1'($urandom), 1'b1);
        waitDrain();

        // Reset in the middle of DECODE drops the block. Output needs
        // 2*TBL fresh columns before it can resume.
        $display("[TB] reset mid-decode");
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * TBL; i++) applyStimulus(1'($urandom), 1'b1);
        idleCycles(TBL + 1);
        rst_n = 1'b0;
        drv_b1 = 1'b0;
        drv_b2 = 1'b0;
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2 * TBL - 1; i++) applyStimulus(1'($urandom), 1'b1);
        idleCycles(3 * TBL);
        checkOutput("midreset_no_early_output", out_valid, 0);
        applyStimulus(1'($urandom), 1'b1);
        waitDrain();

        // Stall in the middle of a block: the presented bit must stay put.
        $display("[TB] stall hold");
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * TBL; i++) applyStimulus(1'($urandom), 1'b1);
        in_valid = 1'b0;
        waitOutValid("stall_block_arrives");
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", out_valid, 1);
            if (exp_q.size() != 0) begin
                checkOutput("hold_out_bit", out_bit, exp_q[0]);
                checkOutput("hold_out_last", out_last, exp_last_q[0]);
            end
        end
        waitDrain();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
